// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants for the VGA output path.
// Counter and sync generators take their defaults from here.
package vga_timing_pkg;

    localparam int COUNT_WIDTH = 11;

    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;

    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;

    typedef logic [COUNT_WIDTH-1:0] cnt_t;

    function automatic int total4(input int a, input int b,
                                  input int c, input int d);
        return a + b + c + d;
    endfunction

    localparam int H_TOTAL = total4(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = total4(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

endpackage

// File: rtl/vga_timing_counter_if.sv
// Position and strobe bundle from the timing counter to the
// sync generators and pixel source.
interface vga_timing_counter_if;
    import vga_timing_pkg::*;

    logic PIX_EN;
    cnt_t HCNT;
    cnt_t VCNT;
    logic VIDEO_ON;
    logic LINE_END;
    logic FRAME_END;

    modport master (
        output PIX_EN, HCNT, VCNT,
        output VIDEO_ON, LINE_END, FRAME_END
    );

    modport slave (
        input PIX_EN, HCNT, VCNT,
        input VIDEO_ON, LINE_END, FRAME_END
    );

endinterface

// File: rtl/vga_timing_counter_pixel_clock_enable.sv
// Pixel-rate enable: one clk-wide pulse every CLK_DIV system clocks,
// so the whole VGA path stays on a single clock.
module pixel_clock_enable #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    output logic PIX_EN
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
        $error("pixel_clock_enable: CLK_DIV must be 1..16");
    end

    logic [DW-1:0] div_cnt_q;
    logic [DW-1:0] div_cnt_d;
    logic          at_last;

    assign at_last = (div_cnt_q == LAST);

    always_comb begin
        div_cnt_d = div_cnt_q + DW'(1);
        if (at_last) begin
            div_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

    assign PIX_EN = at_last && rst;

endmodule

// File: rtl/vga_timing_counter.sv
// Free-running H/V pixel position generator with visible-area
// and line/frame strobes for the VGA output path.
module vga_timing_counter
    import vga_timing_pkg::*;
#(
    parameter int HORIZONTAL_VISIBLE_AREA = H_VISIBLE,
    parameter int HORIZONTAL_FRONT_PORCH  = H_FRONT,
    parameter int HORIZONTAL_SYNC_PULSE   = H_SYNC,
    parameter int HORIZONTAL_BACK_PORCH   = H_BACK,
    parameter int VERTICAL_VISIBLE_AREA   = V_VISIBLE,
    parameter int VERTICAL_FRONT_PORCH    = V_FRONT,
    parameter int VERTICAL_SYNC_PULSE     = V_SYNC,
    parameter int VERTICAL_BACK_PORCH     = V_BACK,
    parameter int CLK_DIV                 = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    vga_timing_counter_if.master vga
);

    localparam int HT = total4(HORIZONTAL_VISIBLE_AREA,
                               HORIZONTAL_FRONT_PORCH,
                               HORIZONTAL_SYNC_PULSE,
                               HORIZONTAL_BACK_PORCH);
    localparam int VT = total4(VERTICAL_VISIBLE_AREA,
                               VERTICAL_FRONT_PORCH,
                               VERTICAL_SYNC_PULSE,
                               VERTICAL_BACK_PORCH);

    if (HT < 1 || HT > 2048) begin : g_bad_h
        $error("vga_timing_counter: H_TOTAL must be 1..2048");
    end
    if (VT < 1 || VT > 2048) begin : g_bad_v
        $error("vga_timing_counter: V_TOTAL must be 1..2048");
    end

    localparam cnt_t        H_LAST = cnt_t'(HT - 1);
    localparam cnt_t        V_LAST = cnt_t'(VT - 1);
    // One bit wider so a visible area of 2048 still compares correctly.
    localparam logic [11:0] H_VIS  = 12'(HORIZONTAL_VISIBLE_AREA);
    localparam logic [11:0] V_VIS  = 12'(VERTICAL_VISIBLE_AREA);

    logic pix_en;
    cnt_t hcnt_q;
    cnt_t hcnt_d;
    cnt_t vcnt_q;
    cnt_t vcnt_d;
    logic h_last;
    logic v_last;

    pixel_clock_enable #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_en (
        .clk    (clk),
        .rst    (rst),
        .PIX_EN (pix_en)
    );

    assign h_last = (hcnt_q == H_LAST);
    assign v_last = (vcnt_q == V_LAST);

    always_comb begin
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (pix_en) begin
            if (h_last) begin
                hcnt_d = '0;
                vcnt_d = v_last ? '0 : vcnt_q + cnt_t'(1);
            end else begin
                hcnt_d = hcnt_q + cnt_t'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

    assign vga.PIX_EN    = pix_en;
    assign vga.HCNT      = hcnt_q;
    assign vga.VCNT      = vcnt_q;
    assign vga.LINE_END  = pix_en && h_last;
    assign vga.FRAME_END = pix_en && h_last && v_last;
    assign vga.VIDEO_ON  = rst
                        && ({1'b0, hcnt_q} < H_VIS)
                        && ({1'b0, vcnt_q} < V_VIS);

endmodule
